// File: rtl/jtframe_sig_pkg.sv
// Shared constants and FSM state type for the frame-signature block.
package jtframe_sig_pkg;

    localparam logic [15:0] CRC_POLY = 16'h1021;
    localparam logic [15:0] CRC_INIT = 16'hFFFF;

    typedef enum logic {
        SYNC   = 1'b0,
        ACTIVE = 1'b1
    } sig_state_e;

endpackage

// File: rtl/jtframe_crc16_step.sv
// One parallel CRC-16-CCITT update over a DW-bit word, MSB shifted in first.
module jtframe_crc16_step
    import jtframe_sig_pkg::*;
#(
    parameter int DW = 12
) (
    input  logic [15:0]   crc_in,
    input  logic [DW-1:0] data,
    output logic [15:0]   crc_out
);

    logic [15:0] w_crc;

    // Unrolled bit-serial LFSR: each data bit, MSB first, is XORed into the feedback tap
    always_comb begin
        w_crc = crc_in;
        for (int i = DW - 1; i >= 0; i--) begin
            if (w_crc[15] ^ data[i]) begin
                w_crc = {w_crc[14:0], 1'b0} ^ CRC_POLY;
            end else begin
                w_crc = {w_crc[14:0], 1'b0};
            end
        end
        crc_out = w_crc;
    end

endmodule

// File: rtl/jtframe_frame_sig.sv
// Frame signature: CRC-16 over active pixels plus active geometry, published once per frame.
//
// sig_valid is a one-clk strobe with no back-pressure: on the cycle it is high,
// frame_cnt/sig_crc/sig_w/sig_h/geom_err carry the new frame's values, and they
// then hold unchanged until the next strobe. The FSM state is held in r_state.
module jtframe_frame_sig
    import jtframe_sig_pkg::*;
#(
    parameter int CW  = 4,
    parameter int FCW = 32,
    parameter int GW  = 9
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           pxl_cen,
    input  logic           pxl_hb,
    input  logic           pxl_vb,
    input  logic [CW-1:0]  red,
    input  logic [CW-1:0]  green,
    input  logic [CW-1:0]  blue,
    output logic [FCW-1:0] frame_cnt,
    output logic [15:0]    sig_crc,
    output logic [GW-1:0]  sig_w,
    output logic [GW-1:0]  sig_h,
    output logic           geom_err,
    output logic           sig_valid
);

    sig_state_e     r_state;
    logic           r_hb_l;
    logic           r_vb_l;
    logic [15:0]    r_crc;
    logic [GW-1:0]  r_h;
    logic [GW-1:0]  r_w_cur;
    logic [GW-1:0]  r_w_ref;
    logic           r_first;
    logic           r_err;

    logic [FCW-1:0] r_frame_cnt;
    logic [15:0]    r_sig_crc;
    logic [GW-1:0]  r_sig_w;
    logic [GW-1:0]  r_sig_h;
    logic           r_geom_err;
    logic           r_sig_valid;

    logic [15:0]    w_crc_next;
    logic           w_pix_act;
    logic           w_hb_rise;
    logic           w_vb_rise;
    logic           w_vb_fall;
    logic           w_line_close;
    logic [GW-1:0]  w_h_next;
    logic [GW-1:0]  w_w_ref_next;
    logic [GW-1:0]  w_w_cur_inc;
    logic           w_err_next;

    jtframe_crc16_step #(
        .DW (3 * CW)
    ) u_crc (
        .crc_in  (r_crc),
        .data    ({red, green, blue}),
        .crc_out (w_crc_next)
    );

    // Edge decode and next-value terms; only meaningful on a pxl_cen sample.
    // A line closing on the same sample as vb rising still counts, because the
    // line belongs to the frame: the "not in vblank" test uses the registered vb.
    always_comb begin
        w_pix_act    = ~pxl_hb & ~pxl_vb;
        w_hb_rise    = pxl_hb & ~r_hb_l;
        w_vb_rise    = pxl_vb & ~r_vb_l;
        w_vb_fall    = ~pxl_vb & r_vb_l;
        w_line_close = w_hb_rise & ~r_vb_l & (r_w_cur != '0);
        w_w_cur_inc  = (r_w_cur == '1) ? r_w_cur : r_w_cur + GW'(1);
        w_h_next     = r_h;
        w_w_ref_next = r_w_ref;
        w_err_next   = r_err;
        if (w_line_close) begin
            w_h_next = (r_h == '1) ? r_h : r_h + GW'(1);
            if (r_first) begin
                w_w_ref_next = r_w_cur;
            end else if (r_w_cur != r_w_ref) begin
                w_err_next = 1'b1;
            end
        end
    end

    // Blank history for edge detection, advancing only with the pixel enable
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_hb_l <= 1'b0;
            r_vb_l <= 1'b0;
        end else if (pxl_cen) begin
            r_hb_l <= pxl_hb;
            r_vb_l <= pxl_vb;
        end
    end

    // FSM with frame accumulation and registered publish outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= SYNC;
            r_crc       <= CRC_INIT;
            r_h         <= '0;
            r_w_cur     <= '0;
            r_w_ref     <= '0;
            r_first     <= 1'b1;
            r_err       <= 1'b0;
            r_frame_cnt <= '0;
            r_sig_crc   <= '0;
            r_sig_w     <= '0;
            r_sig_h     <= '0;
            r_geom_err  <= 1'b0;
            r_sig_valid <= 1'b0;
        end else begin
            r_sig_valid <= 1'b0;
            if (pxl_cen) begin
                case (r_state)
                    SYNC: begin
                        if (w_vb_fall) begin
                            r_crc   <= CRC_INIT;
                            r_h     <= '0;
                            r_w_cur <= '0;
                            r_w_ref <= '0;
                            r_first <= 1'b1;
                            r_err   <= 1'b0;
                            r_state <= ACTIVE;
                        end
                    end
                    ACTIVE: begin
                        if (w_pix_act) begin
                            r_crc   <= w_crc_next;
                            r_w_cur <= w_w_cur_inc;
                        end
                        if (w_line_close) begin
                            r_h     <= w_h_next;
                            r_w_ref <= w_w_ref_next;
                            r_first <= 1'b0;
                            r_err   <= w_err_next;
                            r_w_cur <= '0;
                        end
                        if (w_vb_rise) begin
                            r_sig_crc   <= r_crc;
                            r_sig_w     <= w_w_ref_next;
                            r_sig_h     <= w_h_next;
                            r_geom_err  <= w_err_next;
                            r_frame_cnt <= r_frame_cnt + FCW'(1);
                            r_sig_valid <= 1'b1;
                            r_state     <= SYNC;
                        end
                    end
                endcase
            end
        end
    end

    assign frame_cnt = r_frame_cnt;
    assign sig_crc   = r_sig_crc;
    assign sig_w     = r_sig_w;
    assign sig_h     = r_sig_h;
    assign geom_err  = r_geom_err;
    assign sig_valid = r_sig_valid;

endmodule

// File: doc/jtframe_frame_sig.md
# jtframe_frame_sig

Frame-signature stage that sits directly downstream of the core's raw pixel outputs (`pxl_cen`, `pxl_hb`, `pxl_vb`, 4-bit RGB), alongside the frame dumper in the MiST simulation top. It measures active geometry and computes a CRC-16 over every active pixel. Once per frame it publishes the signature, the geometry and a frame count, so regressions can compare frames without full image dumps. It is synthesizable, so the same block can also drive an on-board debug readout.

## Interface
- `CW`, 4: colour component width.
- `FCW`, 32: frame counter width.
- `GW`, 9: width of the geometry counters for pixels per line and lines per frame.
---
- `clk` in 1: pixel-domain clock, the same clock that gates `pxl_cen`.
- `rst_n` in 1: asynchronous, active-low reset.
- `pxl_cen` in 1: pixel clock enable. All other inputs are sampled only when this is 1.
- `pxl_hb` in 1: horizontal blank, active high.
- `pxl_vb` in 1: vertical blank, active high.
- `red`, `green`, `blue` in CW each: pixel colour.
- `frame_cnt` out FCW: number of completed frames.
- `sig_crc` out 16: CRC of the last completed frame.
- `sig_w` out GW: active pixels per line, taken from the first line of the frame.
- `sig_h` out GW: active lines in the frame.
- `geom_err` out 1: 1 if any line in the last frame had a width different from the first line.
- `sig_valid` out 1: one-`clk` pulse when the outputs above update.

## Operation
- Pixel word: `{red,green,blue}` (3·CW bits, MSB first), fed to a parallel CRC-16-CCITT step.
  - Polynomial 0x1021, init 0xFFFF, no reflection, no final XOR.
- A pixel is active when `pxl_cen & ~pxl_hb & ~pxl_vb`.
- Edge detection uses registered `hb_l`/`vb_l`, which update only on `pxl_cen`.
- FSM states: SYNC, ACTIVE.
  - SYNC is entered at reset and discards the partial first frame. On a `pxl_vb` falling edge it goes to ACTIVE: crc←0xFFFF, h←0, w_cur←0, w_ref←0, first_line←1, err←0.
  - ACTIVE:
    - Each active pixel: crc←step(crc,pix); w_cur←w_cur+1, saturating at 2^GW−1.
    - `pxl_hb` rising edge with `pxl_vb`=0 and w_cur≠0 closes a line:
      - h←h+1, saturating.
      - If first_line: w_ref←w_cur and first_line←0. Otherwise, if w_cur≠w_ref: err←1.
      - Then w_cur←0.
    - `pxl_vb` rising edge publishes the frame:
      - sig_crc←crc, sig_w←w_ref, sig_h←h, geom_err←err.
      - frame_cnt←frame_cnt+1, wrapping at 2^FCW.
      - sig_valid←1 for one `clk`.
      - Then go to SYNC-equivalent wait. The next `pxl_vb` falling edge re-initialises and returns to ACTIVE.
    - Same-sample `pxl_hb` and `pxl_vb` rising edges: the line close is applied first, then the frame publish uses the updated h and err.
- Lines with zero active pixels are not counted.
- A frame with no active pixels publishes crc 0xFFFF, w 0, h 0.
- A reset mid-frame returns to SYNC. That frame is never published.

## Timing
- Reset values: all outputs 0, including `sig_crc`. FSM is in SYNC.
- Publish latency: `sig_valid` and the updated outputs appear on the `clk` edge after the `pxl_cen` sample that saw the `pxl_vb` rising edge.
- `sig_valid` is high for exactly one `clk`, independent of the `pxl_cen` duty cycle.
- Published outputs hold stable until the next publish.
- The CRC step is combinational within one `clk`, with a registered result. Nothing is pipelined.
- `pxl_cen`=0 freezes all internal state except `sig_valid` deassertion.

## Structure
- Package `jtframe_sig_pkg`:
  - `CRC_POLY`=16'h1021, `CRC_INIT`=16'hFFFF.
  - FSM state enum `{SYNC, ACTIVE}`.
- Sub-module `jtframe_crc16_step`: combinational, generic in input width (3·CW). Its inputs are crc_in and data; its output is crc_out. It is unit-tested against the software model.
- Top level holds the edge detectors, FSM, geometry counters and output registers.

## Test plan
- Reset released mid-frame, then 2 frames of 4×3 active pixels, all pixels 12'h000 → first `sig_valid` only after a full frame. sig_w=4, sig_h=3, geom_err=0, frame_cnt=1 then 2. sig_crc equals the model value and matches across both frames.
- Frame with `pxl_hb` held high throughout → sig_crc=16'hFFFF, sig_w=0, sig_h=0, `sig_valid` pulses once.
- Line widths 4, 4, 5 → sig_w=4, sig_h=3, geom_err=1. Next frame with uniform widths → geom_err=0.
- `pxl_cen` at 1/4 duty, same pixel data as the cen=1 run → identical sig_crc, sig_w, sig_h. `sig_valid` is 1 `clk` wide.
- `pxl_hb` and `pxl_vb` rising on the same sample after a 6-pixel line → sig_h includes that line.
- Single pixel 12'hFFF; separately, `rst_n` low for one cycle mid-frame → crc matches the model. After the reset: outputs 0, no publish until the next complete frame.
